// File: rtl/cb_boot_sequencer.sv
// Boot sequencer between the safe-CPU control registers and the safe cluster:
// latches the boot config, releases the harts, and reports completion or abort.
module cb_boot_sequencer #(
  parameter int unsigned NHARTS         = 3,
  parameter int unsigned SLEEP_STABLE   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [31:0]       boot_addr_i,
  input  logic              safe_mode_i,
  input  logic [NHARTS-1:0] master_core_i,
  input  logic [NHARTS-1:0] sleep_i,
  input  logic [NHARTS-1:0] debug_mode_i,
  output logic [NHARTS-1:0] fetch_enable_o,
  output logic [31:0]       core_boot_addr_o,
  output logic              end_sw_o,
  output logic              busy_o,
  output logic              error_o
);

  localparam int unsigned STABLE_W = (SLEEP_STABLE < 1) ? 1 : $clog2(SLEEP_STABLE + 1);
  localparam int unsigned WDOG_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned STABLE_L = (SLEEP_STABLE < 1) ? 0 : SLEEP_STABLE - 1;
  localparam int unsigned WDOG_L   = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(SLEEP_STABLE);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_L);
  localparam logic [WDOG_W-1:0]   WDOG_MAX    = WDOG_W'(TIMEOUT_CYCLES);
  localparam logic [WDOG_W-1:0]   WDOG_LAST   = WDOG_W'(WDOG_L);
  localparam logic                WDOG_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BOOT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  state_e              state_reg, state_next;
  logic                start_q_reg;
  logic [NHARTS-1:0]   mask_reg, mask_next;
  logic [31:0]         addr_reg, addr_next;
  logic [NHARTS-1:0]   fe_reg, fe_next;
  logic                end_sw_reg, end_sw_next;
  logic                busy_reg, busy_next;
  logic                error_reg, error_next;
  logic [STABLE_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic [WDOG_W-1:0]   wdog_reg, wdog_next;

  logic              start_evt;
  logic [NHARTS-1:0] req_mask;
  logic              cfg_bad;
  logic [NHARTS-1:0] hart_ready;
  logic [NHARTS-1:0] hart_dbg;
  logic              qualify;
  logic              dbg_any;
  logic              stable_hit;
  logic              wdog_hit;

  assign start_evt = start_i & ~start_q_reg;
  assign req_mask  = safe_mode_i ? {NHARTS{1'b1}} : master_core_i;
  assign cfg_bad   = (req_mask == '0) || (!safe_mode_i && !$onehot(master_core_i));

  // Inactive harts always count as ready; only active harts can stall completion or pause the watchdog.
  for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart
    assign hart_ready[gi] = ~mask_reg[gi] | (sleep_i[gi] & ~debug_mode_i[gi]);
    assign hart_dbg[gi]   = mask_reg[gi] & debug_mode_i[gi];
  end

  assign qualify    = &hart_ready;
  assign dbg_any    = |hart_dbg;
  assign stable_hit = qualify && (stable_cnt_reg >= STABLE_LAST);
  assign wdog_hit   = WDOG_EN && !dbg_any && (wdog_reg >= WDOG_LAST);

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    addr_next       = addr_reg;
    fe_next         = fe_reg;
    end_sw_next     = end_sw_reg;
    error_next      = error_reg;
    stable_cnt_next = stable_cnt_reg;
    wdog_next       = wdog_reg;

    unique case (state_reg)
      ST_IDLE: begin
        fe_next         = '0;
        end_sw_next     = 1'b0;
        stable_cnt_next = '0;
        wdog_next       = '0;
        if (start_evt) begin
          mask_next = req_mask;
          if (cfg_bad) begin
            state_next = ST_ERROR;
            error_next = 1'b1;
          end else begin
            state_next = ST_BOOT;
            error_next = 1'b0;
            addr_next  = boot_addr_i;
          end
        end
      end
      ST_BOOT: begin
        state_next = ST_RUN;
        fe_next    = mask_reg;
      end
      ST_RUN: begin
        if (!start_i) begin
          state_next = ST_IDLE;
          fe_next    = '0;
        end else if (stable_hit) begin
          state_next  = ST_DONE;
          end_sw_next = 1'b1;
        end else if (wdog_hit) begin
          state_next = ST_ERROR;
          error_next = 1'b1;
          fe_next    = '0;
        end else begin
          if (!qualify) begin
            stable_cnt_next = '0;
          end else if (stable_cnt_reg != STABLE_MAX) begin
            stable_cnt_next = stable_cnt_reg + 1'b1;
          end
          if (!dbg_any && (wdog_reg != WDOG_MAX)) begin
            wdog_next = wdog_reg + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!start_i) begin
          state_next  = ST_IDLE;
          end_sw_next = 1'b0;
          fe_next     = '0;
        end
      end
      ST_ERROR: begin
        fe_next     = '0;
        end_sw_next = 1'b0;
        error_next  = 1'b1;
        if (!start_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        fe_next    = '0;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      start_q_reg    <= 1'b0;
      mask_reg       <= '0;
      addr_reg       <= '0;
      fe_reg         <= '0;
      end_sw_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      error_reg      <= 1'b0;
      stable_cnt_reg <= '0;
      wdog_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      start_q_reg    <= start_i;
      mask_reg       <= mask_next;
      addr_reg       <= addr_next;
      fe_reg         <= fe_next;
      end_sw_reg     <= end_sw_next;
      busy_reg       <= busy_next;
      error_reg      <= error_next;
      stable_cnt_reg <= stable_cnt_next;
      wdog_reg       <= wdog_next;
    end
  end

  assign fetch_enable_o   = fe_reg;
  assign core_boot_addr_o = addr_reg;
  assign end_sw_o         = end_sw_reg;
  assign busy_o           = busy_reg;
  assign error_o          = error_reg;

endmodule
